ccff_chain_loader: RTL
======================

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning bitstream word width.
REQ-002 SHALL have parameter LEN_W, default 16, meaning chain-length counter width.
REQ-003 SHALL have prog_clk  input  1  programming clock; one clock domain, all state on rising edge.
REQ-004 SHALL have prog_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have start  input  1  one-cycle request to begin loading the configuration chain.
REQ-006 SHALL have chain_len  input  LEN_W  number of configuration bits in the chain, sampled when start is accepted.
REQ-007 SHALL have word_data  input  WORD_W  bitstream word.
REQ-008 SHALL have word_valid  input  1  word_data valid.
REQ-009 SHALL have word_ready  output  1  loader accepts word_data this cycle.
REQ-010 SHALL have ccff_head  output  1  serial bit into the chain head.
REQ-011 SHALL have chain_clk_en  output  1  chain shifts on this prog_clk edge (external clock gate).
REQ-012 SHALL have ccff_tail  input  1  serial bit from the chain tail.
REQ-013 SHALL have IO_ISOL_N  output  1  IO isolation to the IO tiles, 0 = isolated.
REQ-014 SHALL have busy, done, err  output  1 each  in progress / one-cycle completion pulse / tail-check failure (sticky).

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, SHIFT, CHECK, FIN.
REQ-016 IDLE: start=1 with chain_len>0 SHALL latch chain_len, clear bit count and err, drive IO_ISOL_N=0, go to LOAD; start with chain_len=0 SHALL go directly to FIN with err=0.
REQ-017 LOAD: word_ready SHALL be 1 (combinational on state only); on word_valid&word_ready the word SHALL load into the shift register and the FSM SHALL go to SHIFT next cycle.
REQ-018 SHIFT: ccff_head SHALL equal shift register bit 0, chain_clk_en SHALL be 1, register SHALL shift right by one and bit count SHALL increment every cycle; bits are sent LSB first.
REQ-019 SHIFT: after WORD_W bits of one word with bit count < chain_len, SHALL return to LOAD; chain_clk_en SHALL be 0 in LOAD, including while word_valid is low (stalls insert no shifts).
REQ-020 When bit count reaches chain_len, SHALL go to CHECK even mid-word; unused upper bits of the last word SHALL be discarded.
REQ-021 The first bit sent SHALL be stored; in CHECK (chain_clk_en=0) ccff_tail SHALL be compared with it, mismatch setting err=1; then go to FIN.
REQ-022 FIN: done SHALL be 1 for exactly one cycle, then IDLE; IO_ISOL_N SHALL become 1 at FIN only if err=0, else remain 0.
REQ-023 busy SHALL be 1 in LOAD, SHIFT, CHECK; start while busy SHALL be ignored.
REQ-024 Bit counter SHALL be LEN_W bits; chain_len = 2^LEN_W-1 SHALL complete without wrap.
REQ-025 word_ready SHALL be 0 in all states except LOAD.

Reset
REQ-026 prog_reset_n low SHALL, asynchronously, force state IDLE, word_ready=0, ccff_head=0, chain_clk_en=0, busy=0, done=0, err=0, IO_ISOL_N=0, counters and shift register 0.
REQ-027 Reset mid-load SHALL abort with no further chain_clk_en pulses; a subsequent start SHALL restart from bit 0.

Structure
REQ-028 FSM state encoding and default WORD_W/LEN_W SHALL live in shared package ccff_loader_pkg.
REQ-029 The serializer (shift register + bit counter) SHALL be sub-module ccff_word_serializer; FSM and tail check stay in the top.

Verification
REQ-030 chain_len=8, one word 0x000000A5, tail looped through an 8-FF chain -> ccff_head sequence 1,0,1,0,0,1,0,1 over 8 chain_clk_en cycles, done pulse, err=0, IO_ISOL_N=1.
REQ-031 chain_len=40, words 0xFFFFFFFF then 0x0000003C, word_valid low 3 cycles between them -> exactly 40 enable pulses, none during stall, 24 upper bits discarded.
REQ-032 chain_len=8, 0x01, tail stuck at 0 -> err=1, IO_ISOL_N stays 0, done pulses once.
REQ-033 chain_len=0 with start -> done next-but-one cycle, word_ready never 1, no enable pulses.
REQ-034 prog_reset_n low after 5 shifted bits -> all outputs at reset values immediately; restart chain_len=8 completes with err=0.
REQ-035 start pulsed during SHIFT -> ignored; bit count and output sequence unchanged.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// Shared definitions for the configuration-chain loader.
//   - Default bitstream word width and chain-length counter width.
//   - Loader FSM state encoding.
package ccff_loader_pkg;

    localparam int WORD_W_DEF = 32;
    localparam int LEN_W_DEF  = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_CHECK = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

endpackage

// File: rtl/ccff_word_serializer.sv
// Word serializer: holds one bitstream word and shifts it out LSB first,
// counting the total bits sent in the current load.
// Ports:
//   clk, rst_n   - programming clock, async active-low reset
//   clear        - start of a new load: zero register and counters
//   load         - capture word_in, restart the per-word bit index
//   shift        - shift right by one, bump both counters
//   word_in      - bitstream word
//   lsb          - current bit 0 of the shift register
//   bit_cnt      - bits sent since clear
//   word_last    - the bit in lsb is the last bit of the current word
module ccff_word_serializer
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] word_in,
    output logic              lsb,
    output logic [LEN_W-1:0]  bit_cnt,
    output logic              word_last
);

    localparam int WB_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [WORD_W-1:0] sreg;
    logic [WB_W-1:0]   wbit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg    <= '0;
            bit_cnt <= '0;
            wbit    <= '0;
        end else if (clear) begin
            sreg    <= '0;
            bit_cnt <= '0;
            wbit    <= '0;
        end else if (load) begin
            sreg <= word_in;
            wbit <= '0;
        end else if (shift) begin
            sreg    <= sreg >> 1;
            bit_cnt <= bit_cnt + LEN_W'(1);
            wbit    <= wbit + WB_W'(1);
        end
    end

    assign lsb       = sreg[0];
    assign word_last = (wbit == WB_W'(WORD_W - 1));

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: pulls bitstream words, shifts chain_len bits
// LSB first into the chain head with a per-cycle clock enable, then checks
// that the first bit sent has emerged at the chain tail.
// Ports:
//   prog_clk, prog_reset_n   - programming clock, async active-low reset
//   start, chain_len         - load request and chain length (bits)
//   word_data/valid/ready    - bitstream word handshake
//   ccff_head, chain_clk_en  - serial data and shift enable to the chain
//   ccff_tail                - serial data back from the chain tail
//   IO_ISOL_N                - IO isolation release (0 = isolated)
//   busy, done, err          - status: in progress / completion pulse / tail mismatch
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  chain_len,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              chain_clk_en,
    input  logic              ccff_tail,
    output logic              IO_ISOL_N,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t           state, state_n;
    logic [LEN_W-1:0] len_q;
    logic             first_bit_q;
    logic             io_q;
    logic             accept, load, shift, err_set;

    logic             lsb, word_last;
    logic [LEN_W-1:0] bit_cnt;

    ccff_word_serializer #(
        .WORD_W (WORD_W),
        .LEN_W  (LEN_W)
    ) u_ser (
        .clk       (prog_clk),
        .rst_n     (prog_reset_n),
        .clear     (accept),
        .load      (load),
        .shift     (shift),
        .word_in   (word_data),
        .lsb       (lsb),
        .bit_cnt   (bit_cnt),
        .word_last (word_last)
    );

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) state <= ST_IDLE;
        else               state <= state_n;
    end

    always_comb begin
        state_n      = state;
        word_ready   = 1'b0;
        chain_clk_en = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        accept       = 1'b0;
        load         = 1'b0;
        shift        = 1'b0;
        err_set      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    // Zero-length chain has nothing to shift or check.
                    state_n = (chain_len != '0) ? ST_LOAD : ST_FIN;
                end
            end
            ST_LOAD: begin
                word_ready = 1'b1;
                busy       = 1'b1;
                if (word_valid) begin
                    load    = 1'b1;
                    state_n = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy         = 1'b1;
                chain_clk_en = 1'b1;
                shift        = 1'b1;
                // bit_cnt < len_q here, so the increment cannot wrap.
                if ((bit_cnt + LEN_W'(1)) == len_q) state_n = ST_CHECK;
                else if (word_last)                 state_n = ST_LOAD;
            end
            ST_CHECK: begin
                busy    = 1'b1;
                err_set = (ccff_tail != first_bit_q);
                state_n = ST_FIN;
            end
            ST_FIN: begin
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            len_q       <= '0;
            err         <= 1'b0;
            first_bit_q <= 1'b0;
            io_q        <= 1'b0;
        end else begin
            if (accept) begin
                len_q <= chain_len;
                err   <= 1'b0;
                io_q  <= 1'b0;
            end
            if (err_set) err <= 1'b1;
            if (shift && bit_cnt == '0) first_bit_q <= lsb;
            if (state == ST_FIN) io_q <= ~err;
        end
    end

    assign ccff_head = (state == ST_SHIFT) ? lsb : 1'b0;
    // Isolation releases in the FIN cycle itself, then holds via io_q.
    assign IO_ISOL_N = io_q | ((state == ST_FIN) && !err);

endmodule
